psg_bus_writer: RTL and testbench

Host-side write sequencer that sits directly upstream of the SN76489-style tone/noise generator and drives its nWE/nCE/D write port. It buffers command bytes from the system bus in a small FIFO. It replays each byte to the sound chip with a strobe long enough for the chip's divided-by-16 internal state machine to capture it. It waits for the chip's READY handshake before issuing the next byte, so software can burst register writes without polling.

---
 rtl/psg_bus_writer.sv | 225 ++++++++++++++++++++++
 tb/tb_psg_bus_writer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psg_bus_writer.sv
`timescale 1ns/1ps
// psg_bus_writer: FIFO-buffered write sequencer driving an SN76489-style nWE/nCE/D port.
// Define PSG_WR_TIMEOUT_EN to enable the READY watchdog and the sticky timeout_err flag.
module psg_bus_writer #(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned SETUP_CYCLES   = 2,
  parameter int unsigned STROBE_MIN     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                             CLK,
  input  logic                             nRST,
  input  logic [7:0]                       in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic                             nWE,
  output logic                             nCE,
  output logic [7:0]                       D,
  input  logic                             READY,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
  output logic                             busy,
  input  logic                             err_clr,
  output logic                             timeout_err
);

  localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LVL_W   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned CNT_MAX = (STROBE_MIN > SETUP_CYCLES) ? STROBE_MIN : SETUP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_RECOVER
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ack_q, ack_d;
  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [7:0]         d_q, d_d;
  logic               nwe_q, nce_q, busy_q;
  logic               push_c, pop_c;

`ifdef PSG_WR_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0]    wd_q, wd_d;
  logic               timeout_c;
  logic               err_q, err_d;
`endif

  assign in_ready   = (level_q < LVL_W'(FIFO_DEPTH));
  assign push_c     = in_valid && in_ready;
  assign fifo_level = level_q;
  assign nWE        = nwe_q;
  assign nCE        = nce_q;
  assign D          = d_q;
  assign busy       = busy_q;

  // Byte storage; contents need no reset since pointers/level define validity.
  always_ff @(posedge CLK) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  always_comb begin
    level_d = level_q;
    case ({push_c, pop_c})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Next-state logic; pop only on IDLE->SETUP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = ack_q;
    pop_c   = 1'b0;
`ifdef PSG_WR_TIMEOUT_EN
    wd_d      = '0;
    timeout_c = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        ack_d = 1'b0;
        if ((level_q != '0) && READY) begin
          pop_c   = 1'b1;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q >= CNT_W'(SETUP_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = ST_STROBE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STROBE: begin
        if (!READY) begin
          ack_d = 1'b1;
        end
        if (cnt_q < CNT_W'(STROBE_MIN)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if ((cnt_d >= CNT_W'(STROBE_MIN)) && ack_d) begin
          cnt_d   = '0;
          state_d = ST_HOLD;
        end
`ifdef PSG_WR_TIMEOUT_EN
        else if (!ack_d) begin
          wd_d = wd_q + WD_W'(1);
          if (wd_d >= WD_W'(TIMEOUT_CYCLES)) begin
            timeout_c = 1'b1;
          end
        end else begin
          wd_d = wd_q;
        end
`endif
      end
      ST_HOLD: begin
        state_d = ST_RECOVER;
      end
      ST_RECOVER: begin
        if (READY) begin
          state_d = ST_IDLE;
        end
`ifdef PSG_WR_TIMEOUT_EN
        else begin
          wd_d = wd_q + WD_W'(1);
          if (wd_d >= WD_W'(TIMEOUT_CYCLES)) begin
            timeout_c = 1'b1;
          end
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
`ifdef PSG_WR_TIMEOUT_EN
    // Watchdog abandons the current byte and releases the chip.
    if (timeout_c) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      ack_d   = 1'b0;
      wd_d    = '0;
    end
`endif
  end

  always_comb begin
    d_d = d_q;
    if (pop_c) begin
      d_d = mem_q[rd_ptr_q];
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      ack_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      d_q      <= 8'h00;
      nwe_q    <= 1'b1;
      nce_q    <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      level_q  <= level_d;
      d_q      <= d_d;
      if (push_c) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      // Chip strobes follow the next state so they are glitch-free registers.
      nwe_q  <= (state_d != ST_STROBE);
      nce_q  <= !((state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD));
      busy_q <= (state_d != ST_IDLE) || (level_d != '0);
    end
  end

`ifdef PSG_WR_TIMEOUT_EN
  // Sticky error: a new timeout wins over a simultaneous clear.
  always_comb begin
    err_d = err_q;
    if (timeout_c) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign timeout_err = err_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr ^ (TIMEOUT_CYCLES == 0);
  assign timeout_err    = 1'b0;
`endif

endmodule

// File: tb/tb_psg_bus_writer.sv
`timescale 1ns/1ps
// Directed self-checking bench for psg_bus_writer with a simple PSG READY responder.
module tb_psg_bus_writer;

  localparam int unsigned FIFO_DEPTH     = 8;
  localparam int unsigned SETUP_CYCLES   = 2;
  localparam int unsigned STROBE_MIN     = 16;
  localparam int unsigned TIMEOUT_CYCLES = 256;

  logic       CLK = 1'b0;
  logic       nRST = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       nWE, nCE;
  logic [7:0] D;
  logic       READY;
  logic [3:0] fifo_level;
  logic       busy;
  logic       err_clr = 1'b0;
  logic       timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Chip model state: manual READY level or an automatic response to each nWE fall.
  logic auto_mode = 1'b0;
  logic ready_man = 1'b1;
  logic auto_ready = 1'b1;
  logic prev_nwe = 1'b1;
  bit   resp_active = 1'b0;
  int   resp_cnt = 0;
  int   cur_w = 0;
  int   nce_bad = 0;
  logic [7:0] cap_d[$];
  int         cap_w[$];

  assign READY = auto_mode ? auto_ready : ready_man;

  always #5 CLK = ~CLK;

  psg_bus_writer #(
    .FIFO_DEPTH(FIFO_DEPTH), .SETUP_CYCLES(SETUP_CYCLES),
    .STROBE_MIN(STROBE_MIN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .CLK(CLK), .nRST(nRST), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .nWE(nWE), .nCE(nCE), .D(D), .READY(READY), .fifo_level(fifo_level), .busy(busy),
    .err_clr(err_clr), .timeout_err(timeout_err)
  );

  // READY drops 3 cycles after nWE falls and returns 16 cycles later; also logs each write.
  always @(negedge CLK) begin
    if (!auto_mode) begin
      resp_active = 1'b0;
      auto_ready  = 1'b1;
    end else if (resp_active) begin
      resp_cnt++;
      if (resp_cnt == 3) auto_ready = 1'b0;
      else if (resp_cnt == 19) begin
        auto_ready  = 1'b1;
        resp_active = 1'b0;
      end
    end else if (nWE === 1'b0 && prev_nwe === 1'b1) begin
      resp_active = 1'b1;
      resp_cnt    = 0;
    end
    if (nWE === 1'b0) begin
      if (prev_nwe === 1'b1) begin
        cap_d.push_back(D);
        cur_w = 0;
      end
      cur_w++;
      if (nCE !== 1'b0) nce_bad++;
    end else if (prev_nwe === 1'b0) begin
      cap_w.push_back(cur_w);
    end
    prev_nwe = nWE;
  end

  task automatic push_byte(input logic [7:0] b);
    @(negedge CLK);
    in_data  = b;
    in_valid = 1'b1;
    @(negedge CLK);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int i = 0;
    while (busy !== 1'b0 && i < max_cyc) begin
      @(negedge CLK);
      i++;
    end
  endtask

  task automatic test_reset;
    #2 nRST = 1'b0;
    repeat (3) @(negedge CLK);
    n_checks += 7;
    if (nWE !== 1'b1)         begin n_fail++; $display("FAIL reset_nwe: got %b want 1", nWE); end
    if (nCE !== 1'b1)         begin n_fail++; $display("FAIL reset_nce: got %b want 1", nCE); end
    if (D !== 8'h00)          begin n_fail++; $display("FAIL reset_d: got %h want 00", D); end
    if (fifo_level !== 4'd0)  begin n_fail++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    if (busy !== 1'b0)        begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_terr: got %b want 0", timeout_err); end
    if (in_ready !== 1'b1)    begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(negedge CLK) nRST = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_single_write;
    int db = cap_d.size();
    int wb = cap_w.size();
    int nb = nce_bad;
    auto_mode = 1'b1;
    push_byte(8'h9F);
    n_checks += 2;
    if (fifo_level !== 4'd1) begin n_fail++; $display("FAIL single_level_after_push: got %0d want 1", fifo_level); end
    if (nCE !== 1'b1)        begin n_fail++; $display("FAIL single_nce_after_push: got %b want 1", nCE); end
    @(negedge CLK);
    n_checks += 4;
    if (nCE !== 1'b0)        begin n_fail++; $display("FAIL single_nce_setup: got %b want 0", nCE); end
    if (D !== 8'h9F)         begin n_fail++; $display("FAIL single_d_setup: got %h want 9f", D); end
    if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL single_level_pop: got %0d want 0", fifo_level); end
    if (nWE !== 1'b1)        begin n_fail++; $display("FAIL single_nwe_setup0: got %b want 1", nWE); end
    @(negedge CLK);
    n_checks++;
    if (nWE !== 1'b1) begin n_fail++; $display("FAIL single_nwe_setup1: got %b want 1", nWE); end
    @(negedge CLK);
    n_checks++;
    if (nWE !== 1'b0) begin n_fail++; $display("FAIL single_nwe_strobe: got %b want 0", nWE); end
    wait_idle(200);
    n_checks += 6;
    if (busy !== 1'b0)          begin n_fail++; $display("FAIL single_busy_end: got %b want 0", busy); end
    if (fifo_level !== 4'd0)    begin n_fail++; $display("FAIL single_level_end: got %0d want 0", fifo_level); end
    if (cap_d.size() != db + 1) begin n_fail++; $display("FAIL single_write_count: got %0d want 1", cap_d.size() - db); end
    else if (cap_d[db] !== 8'h9F) begin n_fail++; $display("FAIL single_d_strobe: got %h want 9f", cap_d[db]); end
    if (cap_w.size() != wb + 1) begin n_fail++; $display("FAIL single_pulse_count: got %0d want 1", cap_w.size() - wb); end
    else if (cap_w[wb] < STROBE_MIN) begin n_fail++; $display("FAIL single_pulse_width: got %0d want >=%0d", cap_w[wb], STROBE_MIN); end
    if (nce_bad != nb)          begin n_fail++; $display("FAIL single_nce_strobe: got %0d high cycles want 0", nce_bad - nb); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] burst [10];
    int db = cap_d.size();
    int wb = cap_w.size();
    int idx = 0;
    int guard = 0;
    int full_bad = 0;
    int short_w = 0;
    bit saw_full = 1'b0;
    bit acc;
    burst = '{8'h80, 8'h00, 8'h91, 8'h11, 8'hA2, 8'h22, 8'hB3, 8'h33, 8'hC4, 8'h44};
    auto_mode = 1'b1;
    @(negedge CLK);
    while (idx < 10 && guard < 2000) begin
      in_data  = burst[idx];
      in_valid = 1'b1;
      acc = in_ready;
      if (fifo_level == 4'(FIFO_DEPTH)) begin
        saw_full = 1'b1;
        if (in_ready !== 1'b0) full_bad++;
      end else if (in_ready !== 1'b1) full_bad++;
      @(negedge CLK);
      if (acc) idx++;
      guard++;
    end
    in_valid = 1'b0;
    wait_idle(2000);
    for (int i = wb; i < cap_w.size(); i++) if (cap_w[i] < STROBE_MIN) short_w++;
    n_checks += 6;
    if (idx != 10)          begin n_fail++; $display("FAIL b2b_accepted: got %0d want 10", idx); end
    if (saw_full !== 1'b1)  begin n_fail++; $display("FAIL b2b_reached_full: got %b want 1", saw_full); end
    if (full_bad != 0)      begin n_fail++; $display("FAIL b2b_in_ready: got %0d wrong cycles want 0", full_bad); end
    if (busy !== 1'b0)      begin n_fail++; $display("FAIL b2b_busy_end: got %b want 0", busy); end
    if (short_w != 0)       begin n_fail++; $display("FAIL b2b_pulse_width: got %0d short pulses want 0", short_w); end
    if (cap_d.size() != db + 10) begin
      n_fail++; $display("FAIL b2b_write_count: got %0d want 10", cap_d.size() - db);
    end else begin
      for (int i = 0; i < 10; i++) begin
        n_checks++;
        if (cap_d[db+i] !== burst[i]) begin n_fail++; $display("FAIL b2b_order[%0d]: got %h want %h", i, cap_d[db+i], burst[i]); end
      end
    end
  endtask

  task automatic test_push_pop_same_edge;
    int db = cap_d.size();
    auto_mode = 1'b0;
    ready_man = 1'b0;
    push_byte(8'h81);
    push_byte(8'h92);
    push_byte(8'hA3);
    n_checks += 2;
    if (fifo_level !== 4'd3) begin n_fail++; $display("FAIL pp_level_pre: got %0d want 3", fifo_level); end
    if (nCE !== 1'b1)        begin n_fail++; $display("FAIL pp_nce_pre: got %b want 1", nCE); end
    @(negedge CLK);
    ready_man = 1'b1;
    in_data   = 8'h55;
    in_valid  = 1'b1;
    @(negedge CLK);
    in_valid  = 1'b0;
    auto_mode = 1'b1;
    n_checks += 3;
    if (fifo_level !== 4'd3) begin n_fail++; $display("FAIL pp_level_same_edge: got %0d want 3", fifo_level); end
    if (nCE !== 1'b0)        begin n_fail++; $display("FAIL pp_nce_post: got %b want 0", nCE); end
    if (D !== 8'h81)         begin n_fail++; $display("FAIL pp_d_post: got %h want 81", D); end
    wait_idle(1000);
    n_checks += 2;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL pp_busy_end: got %b want 0", busy); end
    if (cap_d.size() != db + 4) begin n_fail++; $display("FAIL pp_write_count: got %0d want 4", cap_d.size() - db); end
    else if (cap_d[db+3] !== 8'h55) begin n_fail++; $display("FAIL pp_last_byte: got %h want 55", cap_d[db+3]); end
  endtask

  task automatic test_ready_low;
    int db = cap_d.size();
    auto_mode = 1'b0;
    ready_man = 1'b0;
    push_byte(8'h9A);
    repeat (5) @(negedge CLK);
    n_checks += 3;
    if (nCE !== 1'b1)        begin n_fail++; $display("FAIL rl_nce_blocked: got %b want 1", nCE); end
    if (nWE !== 1'b1)        begin n_fail++; $display("FAIL rl_nwe_blocked: got %b want 1", nWE); end
    if (fifo_level !== 4'd1) begin n_fail++; $display("FAIL rl_level_blocked: got %0d want 1", fifo_level); end
    ready_man = 1'b1;
    auto_mode = 1'b1;
    @(negedge CLK);
    n_checks += 3;
    if (nCE !== 1'b0)        begin n_fail++; $display("FAIL rl_nce_released: got %b want 0", nCE); end
    if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL rl_level_released: got %0d want 0", fifo_level); end
    if (D !== 8'h9A)         begin n_fail++; $display("FAIL rl_d_released: got %h want 9a", D); end
    wait_idle(200);
    n_checks += 2;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rl_busy_end: got %b want 0", busy); end
    if (cap_d.size() != db + 1) begin n_fail++; $display("FAIL rl_write_count: got %0d want 1", cap_d.size() - db); end
  endtask

  task automatic test_reset_mid_write;
    int i = 0;
    auto_mode = 1'b1;
    for (int k = 0; k < 5; k++) push_byte(8'(8'h10 + k));
    while (nWE !== 1'b0 && i < 50) begin
      @(negedge CLK);
      i++;
    end
    n_checks += 2;
    if (nWE !== 1'b0)        begin n_fail++; $display("FAIL rst_mid_strobe: got nWE=%b want 0", nWE); end
    if (fifo_level !== 4'd4) begin n_fail++; $display("FAIL rst_mid_level_pre: got %0d want 4", fifo_level); end
    #2 nRST = 1'b0;
    #1;
    n_checks += 6;
    if (nWE !== 1'b1)        begin n_fail++; $display("FAIL rst_mid_nwe: got %b want 1", nWE); end
    if (nCE !== 1'b1)        begin n_fail++; $display("FAIL rst_mid_nce: got %b want 1", nCE); end
    if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL rst_mid_level: got %0d want 0", fifo_level); end
    if (D !== 8'h00)         begin n_fail++; $display("FAIL rst_mid_d: got %h want 00", D); end
    if (busy !== 1'b0)       begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    if (in_ready !== 1'b1)   begin n_fail++; $display("FAIL rst_mid_in_ready: got %b want 1", in_ready); end
    auto_mode = 1'b0;
    ready_man = 1'b1;
    @(negedge CLK) nRST = 1'b1;
    repeat (5) @(negedge CLK);
    n_checks += 2;
    if (nCE !== 1'b1)  begin n_fail++; $display("FAIL rst_mid_flushed_nce: got %b want 1", nCE); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_flushed_busy: got %b want 0", busy); end
  endtask

`ifdef PSG_WR_TIMEOUT_EN
  task automatic test_timeout;
    int wb = cap_w.size();
    int db;
    int i = 0;
    auto_mode = 1'b0;
    ready_man = 1'b1;
    push_byte(8'h3C);
    while (timeout_err !== 1'b1 && i < 400) begin
      @(negedge CLK);
      i++;
    end
    n_checks += 4;
    if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_flag_set: got %b want 1", timeout_err); end
    if (nWE !== 1'b1)         begin n_fail++; $display("FAIL to_nwe_released: got %b want 1", nWE); end
    if (nCE !== 1'b1)         begin n_fail++; $display("FAIL to_nce_released: got %b want 1", nCE); end
    if (cap_w.size() != wb + 1) begin n_fail++; $display("FAIL to_pulse_count: got %0d want 1", cap_w.size() - wb); end
    else if (cap_w[wb] != TIMEOUT_CYCLES) begin n_fail++; $display("FAIL to_pulse_width: got %0d want %0d", cap_w[wb], TIMEOUT_CYCLES); end
    repeat (3) @(negedge CLK);
    n_checks++;
    if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_flag_sticky: got %b want 1", timeout_err); end
    err_clr = 1'b1;
    @(negedge CLK);
    err_clr = 1'b0;
    n_checks++;
    if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_flag_clear: got %b want 0", timeout_err); end
    db = cap_d.size();
    auto_mode = 1'b1;
    push_byte(8'hC7);
    wait_idle(200);
    n_checks += 3;
    if (busy !== 1'b0)        begin n_fail++; $display("FAIL to_next_busy: got %b want 0", busy); end
    if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_next_flag: got %b want 0", timeout_err); end
    if (cap_d.size() != db + 1) begin n_fail++; $display("FAIL to_next_count: got %0d want 1", cap_d.size() - db); end
    else if (cap_d[db] !== 8'hC7) begin n_fail++; $display("FAIL to_next_byte: got %h want c7", cap_d[db]); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_push_pop_same_edge();
    test_ready_low();
    test_reset_mid_write();
`ifdef PSG_WR_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
